// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry sequencer.
package rca_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } rca_seq_state_e;

endpackage

// File: rtl/rca_seq_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry slice exposing every per-bit carry.
module nibble_adder
  import rca_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic [NIBBLE_W-1:0] carry
);

  logic [NIBBLE_W:0] chain;

  always_comb begin
    chain    = '0;
    sum      = '0;
    chain[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ chain[i];
      chain[i + 1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end
    carry = chain[NIBBLE_W:1];
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequencer adding WIDTH-bit operands one nibble per cycle through a single slice.
// Optional subtract support (sub port) is enabled by defining RCA_SEQ_SUBTRACT_EN.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NIBBLES = WIDTH / NIBBLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef RCA_SEQ_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W || NIBBLES * NIBBLE_W != WIDTH) begin : g_bad_width
    $error("rca_seq_ctrl: WIDTH must be a non-zero multiple of 4 and NIBBLES must equal WIDTH/4");
  end

  rca_seq_state_e   state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic             cout_d, ovf_d, ready_d, valid_d;
  logic             c_init;

  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum, slice_carry;
  logic                unused_low_carries;

`ifdef RCA_SEQ_SUBTRACT_EN
  logic sub_q, sub_d;
  // Subtraction is a + ~b + 1: invert B per slice and seed the carry.
  assign slice_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
  assign c_init  = sub;
`else
  assign slice_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign c_init  = 1'b0;
`endif

  assign slice_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];

  nibble_adder u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (c_q),
    .sum   (slice_sum),
    .carry (slice_carry)
  );

  // Only the top two slice carries matter outside the slice itself.
  assign unused_low_carries = ^slice_carry[1:0];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    c_d     = c_q;
    sum_d   = sum;
    cout_d  = cout;
    ovf_d   = overflow;
`ifdef RCA_SEQ_SUBTRACT_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          c_d     = c_init;
          sum_d   = '0;
`ifdef RCA_SEQ_SUBTRACT_EN
          sub_d   = sub;
`endif
        end
      end
      RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_sum;
        c_d = slice_carry[NIBBLE_W-1];
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          cout_d  = slice_carry[NIBBLE_W-1];
          ovf_d   = slice_carry[NIBBLE_W-1] ^ slice_carry[NIBBLE_W-2];
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      c_q       <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
`ifdef RCA_SEQ_SUBTRACT_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      c_q       <= c_d;
      sum       <= sum_d;
      cout      <= cout_d;
      overflow  <= ovf_d;
      in_ready  <= ready_d;
      out_valid <= valid_d;
`ifdef RCA_SEQ_SUBTRACT_EN
      sub_q     <= sub_d;
`endif
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Randomised and directed bench for rca_seq_ctrl against an arithmetic reference model.
module tb_rca_seq_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, overflow;
  logic [W-1:0] sum;
  logic         sub_eff;

  int          checks = 0;
  int          errs = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef RCA_SEQ_SUBTRACT_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

`ifdef RCA_SEQ_SUBTRACT_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Result as {overflow, cout, sum}, from integer arithmetic on the operand values.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int sx, sy, r;
    logic o, c;
    logic [W-1:0] sm;
    sx = int'($signed(x));
    sy = s ? -int'($signed(y)) : int'($signed(y));
    r  = sx + sy;
    o  = (r > 32767) || (r < -32768);
    c  = s ? (x >= y) : ((int'(x) + int'(y)) > 65535);
    sm = s ? x - y : x + y;
    return {o, c, sm};
  endfunction

  // Transaction-level model: readiness, result latency and pending result.
  logic         m_ready = 1'b0, m_valid = 1'b0, m_known = 1'b0;
  logic         m_cout = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic [W+1:0] m_pend = '0;
  int           m_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready <= 1'b0; m_valid <= 1'b0; m_cnt <= 0; m_known <= 1'b1;
      m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid <= 1'b1; m_known <= 1'b1;
        {m_ovf, m_cout, m_sum} <= m_pend;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0; m_ready <= 1'b1; m_known <= 1'b0;
      end
    end else if (m_ready) begin
      if (in_valid) begin
        m_ready <= 1'b0; m_cnt <= N; m_known <= 1'b0;
        m_pend  <= ref_op(a, b, sub_eff);
      end
    end else begin
      m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(in_ready), 32'(m_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_known) begin
      check("sum", 32'(sum), 32'(m_sum));
      check("cout", 32'(cout), 32'(m_cout));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("wait_in_ready", 32'(n < 30), 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       output int unsigned acc);
    int n;
    wait_ready();
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(N));
    check("op_sum", 32'(sum), 32'(es));
    check("op_cout", 32'(cout), 32'(ec));
    check("op_overflow", 32'(overflow), 32'(eo));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc1, acc2, dummy;

    check("model_pin_wrap", 32'(ref_op(16'hFFFF, 16'h0001, 1'b0)), 32'h10000);
    check("model_pin_ovf", 32'(ref_op(16'h7FFF, 16'h0001, 1'b0)), 32'h28000);
    check("model_pin_neg", 32'(ref_op(16'h8000, 16'h8000, 1'b0)), 32'h30000);
    check("model_pin_sub", 32'(ref_op(16'h0005, 16'h0007, 1'b1)), 32'h0FFFE);

    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'h1234; b = 16'h1111;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, dummy);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, dummy);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, dummy);

    do_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, acc1);
    do_op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, acc2);
    check("b2b_interval", 32'(acc2 - acc1), 32'(N + 2));

    // Backpressure: stall in DONE while new operands are offered.
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 1'b0, dummy);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
      @(posedge clk); #1;
      check("bp_sum", 32'(sum), 32'h2143);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_overflow", 32'(overflow), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'(out_valid), 32'd0);

    // Reset two nibble edges into a run.
    wait_ready();
    a = 16'h5555; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_release_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, dummy);

`ifdef RCA_SEQ_SUBTRACT_EN
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, dummy);
    do_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, dummy);
`endif

    // Random traffic, backpressure and occasional resets, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      a         = 16'($urandom);
      b         = 16'($urandom);
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
